player1_recorder: RTL and testbench
===================================

# player1_recorder

Records player 1's secret code into the shared 32x4 code RAM that player 2 later reads back and compares against. During each symbol slot the block samples the player key on every 1 Hz tick into a 4-bit shift register. When the player presses "next", the symbol is committed to the next RAM address. Recording ends on "done" or when the memory is full, leaving a symbol count for the player 2 side.

## Interface
Parameters:
- `DEPTH`, default 32: number of RAM entries. Must be a power of two and at most 32.
- `SYM_W`, default 4: symbol width. Matches the RAM data width.

Ports:
- `clock`  in  1: system clock (CLOCK_50 domain).
- `resetn`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle sample strobe from the rate divider (1 Hz in the game).
- `start`  in  1: one-cycle pulse from the top-level FSM on entry to the P1 turn.
- `user_input`  in  1: raw key, active-low (low means pressed).
- `next_input`  in  1: raw key, active-low; commits the current symbol.
- `done_input`  in  1: raw key, active-low; ends recording.
- `ram_addr`  out  5: write address.
- `ram_data`  out  `SYM_W`: write data.
- `ram_wren`  out  1: write enable, one cycle per commit.
- `length`  out  6: number of symbols written, range 0..`DEPTH`.
- `cur_symbol`  out  `SYM_W`: live shift register contents, used for the LEDG display.
- `busy`  out  1: high in RECORD and WRITE.
- `recorded`  out  1: high in DONE.

## Operation
- All three keys pass through a 2-flop synchronizer.
- `next_input` and `done_input` are also press-edge detected: previous synced value 1 and current synced value 0.
- FSM states and transitions:
  - IDLE: waits for `start`. On `start`: `wr_ptr`=0, `length`=0, `sym`=0, pend=0, go to RECORD.
  - RECORD:
    - On `tick`: `sym` <= {`sym`[`SYM_W`-2:0], pressed}, where pressed = ~synced `user_input`.
    - On a next edge: go to WRITE.
    - On a done edge alone: go to DONE. The partial symbol is discarded.
    - On next and done edges in the same cycle: set pend=1 and go to WRITE.
  - WRITE (exactly one cycle):
    - `ram_wren`=1, `ram_addr`=`wr_ptr`, `ram_data`=`sym`.
    - On exit: `wr_ptr`++, `length`++, `sym`=0.
    - Go to DONE if pend=1 or `wr_ptr`==`DEPTH`-1; otherwise go to RECORD.
  - DONE: holds `length`. `start` re-enters RECORD with a full clear. The RAM is not cleared.
- `tick` in the same cycle as a next edge: the shift is applied first, so the written symbol includes that sample.
- `tick` during WRITE, IDLE or DONE is ignored.
- Key edges in IDLE, WRITE or DONE are ignored. Exception: a done edge during WRITE sets pend.
- `start` while in RECORD or WRITE restarts the recording. Any write already issued stands.
- Full condition: after the `DEPTH`-th write the FSM goes to DONE, so `length`=`DEPTH`. No address wrap occurs.
- `cur_symbol` = `sym` at all times.

## Timing
- Reset (asynchronous): state=IDLE, all outputs 0, synchronizer flops = 1 (keys released).
- Key latency: a key low before rising edge k produces an edge pulse after edge k+2. The FSM reacts at edge k+3.
- Sampling latency: `user_input` is likewise sampled two cycles late relative to `tick`.
- Commit: `ram_wren` is high for exactly one cycle, after edge k+3. The RAM captures the write at edge k+4.
- `length` and `wr_ptr` update on that same edge k+4.
- `ram_addr` and `ram_data` are registered and stable for the whole `ram_wren` cycle. Outside WRITE, `ram_data` is 0.
- A held key produces exactly one edge. Another commit requires a release followed by a new press.

## Test plan
- Reset mid-RECORD: assert `resetn`=0 asynchronously between clock edges. Outputs clear immediately; `recorded`=0; state=IDLE.
- Basic commit:
  - Stimulus: `start`; key held low across ticks 1 and 3, high across ticks 2 and 4; then press next.
  - Required: one `ram_wren` pulse with addr=0, data=4'b1010; `length`=1; `cur_symbol` returns to 0.
- Three symbols then done:
  - Stimulus: commit 4'b0001, 4'b0011, 4'b1111 in turn, then press done.
  - Required: writes at addr 0, 1, 2; `recorded`=1; `length`=3; `busy`=0.
- Simultaneous next and done edges with `sym`=4'b0101:
  - Required: one write of 4'b0101, then DONE with `length` incremented.
- Full memory:
  - Stimulus: 32 next presses, then a 33rd press.
  - Required: addresses 0..31 written; DONE reached after the 32nd write with `length`=32; the 33rd press produces no `ram_wren`.
- Tick coincident with the next-edge cycle, and a held next key:
  - Tick coincident with the next edge: the written symbol includes that sample.
  - Next key held for 10 s: exactly one write.

Source files
------------

// File: rtl/player1_recorder.sv
// -----------------------------------------------------------------------------
// player1_recorder
// Records player 1's secret code into the shared code RAM. Each symbol is built
// by shifting the (synchronized) player key into a shift register on every
// sample tick; a "next" press commits the symbol to the next RAM address and a
// "done" press (or a full memory) ends recording, leaving the symbol count on
// `length` for the player 2 side.
//
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   tick               one-cycle sample strobe
//   start              one-cycle pulse: begin (or restart) a recording
//   user_input         player key, active-low
//   next_input         commit key, active-low
//   done_input         finish key, active-low
//   ram_addr/ram_data  registered write address / data (data is 0 outside WRITE)
//   ram_wren           one-cycle write enable per commit
//   length             number of symbols written (0..DEPTH)
//   cur_symbol         live shift register contents
//   busy               high while recording or writing
//   recorded           high once recording has finished
// -----------------------------------------------------------------------------
module player1_recorder #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned SYM_W = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             tick,
   input  logic             start,
   input  logic             user_input,
   input  logic             next_input,
   input  logic             done_input,
   output logic [4:0]       ram_addr,
   output logic [SYM_W-1:0] ram_data,
   output logic             ram_wren,
   output logic [5:0]       length,
   output logic [SYM_W-1:0] cur_symbol,
   output logic             busy,
   output logic             recorded
);

   localparam int unsigned AW = 5;
   localparam int unsigned LW = 6;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_next;

   // Key synchronizers; bit 1 is the synchronized value.
   logic [1:0] user_sync, next_sync, done_sync;
   logic       next_prev, done_prev;
   logic       next_edge, done_edge;

   logic [AW-1:0]    wr_ptr;
   logic [SYM_W-1:0] sym;
   logic             pend;

   // Control strobes from the next-state logic.
   logic clear_all, do_shift, load_write, end_write, discard, pend_set;

   logic             pressed;
   logic [SYM_W-1:0] sym_shift;

   assign pressed    = ~user_sync[1];
   assign sym_shift  = {sym[SYM_W-2:0], pressed};
   assign cur_symbol = sym;

   // Two-flop synchronizers plus registered press-edge (1 -> 0) detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         user_sync <= 2'b11;
         next_sync <= 2'b11;
         done_sync <= 2'b11;
         next_prev <= 1'b1;
         done_prev <= 1'b1;
         next_edge <= 1'b0;
         done_edge <= 1'b0;
      end else begin
         user_sync <= {user_sync[0], user_input};
         next_sync <= {next_sync[0], next_input};
         done_sync <= {done_sync[0], done_input};
         next_prev <= next_sync[1];
         done_prev <= done_sync[1];
         next_edge <= next_prev & ~next_sync[1];
         done_edge <= done_prev & ~done_sync[1];
      end
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state and control decode.
   always_comb begin
      state_next = state;
      clear_all  = 1'b0;
      do_shift   = 1'b0;
      load_write = 1'b0;
      end_write  = 1'b0;
      discard    = 1'b0;
      pend_set   = 1'b0;

      if (start) begin
         // Start restarts from any state; a write already on the bus stands.
         clear_all  = 1'b1;
         state_next = RECORD;
      end else begin
         case (state)
            RECORD: begin
               do_shift = tick;
               if (next_edge) begin
                  load_write = 1'b1;
                  pend_set   = done_edge;
                  state_next = WRITE;
               end else if (done_edge) begin
                  discard    = 1'b1;
                  state_next = DONE;
               end
            end
            WRITE: begin
               end_write = 1'b1;
               if (pend || done_edge || (wr_ptr == LAST_ADDR)) state_next = DONE;
               else                                          state_next = RECORD;
            end
            default: ;
         endcase
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr   <= '0;
         length   <= '0;
         sym      <= '0;
         pend     <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
         busy     <= 1'b0;
         recorded <= 1'b0;
      end else begin
         ram_wren <= 1'b0;
         ram_data <= '0;
         busy     <= (state_next == RECORD) || (state_next == WRITE);
         recorded <= (state_next == DONE);
         if (clear_all) begin
            wr_ptr   <= '0;
            length   <= '0;
            sym      <= '0;
            pend     <= 1'b0;
            ram_addr <= '0;
         end else begin
            if (do_shift) sym <= sym_shift;
            // Tick in the commit cycle is applied before the symbol is written.
            if (load_write) begin
               ram_wren <= 1'b1;
               ram_addr <= wr_ptr;
               ram_data <= do_shift ? sym_shift : sym;
            end
            if (pend_set) pend <= 1'b1;
            if (discard)  sym  <= '0;
            if (end_write) begin
               wr_ptr <= AW'(wr_ptr + AW'(1));
               length <= LW'(length + LW'(1));
               sym    <= '0;
               pend   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_player1_recorder.sv
// -----------------------------------------------------------------------------
// tb_player1_recorder
// Directed bench for player1_recorder: drives keys/ticks, collects RAM writes
// at the falling edge, and compares against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_player1_recorder;

   logic       clock = 1'b0;
   logic       resetn;
   logic       tick, start, user_input, next_input, done_input;
   logic [4:0] ram_addr;
   logic [3:0] ram_data;
   logic       ram_wren;
   logic [5:0] length;
   logic [3:0] cur_symbol;
   logic       busy, recorded;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] wq[$];

   player1_recorder #(.DEPTH(32), .SYM_W(4)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .tick       (tick),
      .start      (start),
      .user_input (user_input),
      .next_input (next_input),
      .done_input (done_input),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_wren   (ram_wren),
      .length     (length),
      .cur_symbol (cur_symbol),
      .busy       (busy),
      .recorded   (recorded)
   );

   always #5 clock = ~clock;

   // Capture every cycle of write enable (a stretched pulse shows up twice).
   always @(negedge clock) begin
      if (ram_wren) wq.push_back({ram_addr, ram_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(1);
   endtask

   // Hold the player key at b long enough to synchronize, then one tick.
   task automatic sample_bit(input logic b);
      user_input = ~b;
      step(3);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
   endtask

   task automatic press_next();
      next_input = 1'b0;
      step(8);
      next_input = 1'b1;
      step(8);
   endtask

   task automatic press_done();
      done_input = 1'b0;
      step(8);
      done_input = 1'b1;
      step(8);
   endtask

   task automatic press_both();
      next_input = 1'b0;
      done_input = 1'b0;
      step(8);
      next_input = 1'b1;
      done_input = 1'b1;
      step(8);
   endtask

   task automatic check_write(input string tag, input int idx, input logic [4:0] addr,
                              input logic [3:0] data);
      logic [8:0] e;
      if (idx < wq.size()) begin
         e = wq[idx];
         check({tag, "_addr"}, 32'(e[8:4]), 32'(addr));
         check({tag, "_data"}, 32'(e[3:0]), 32'(data));
      end else begin
         check({tag, "_present"}, 32'(wq.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      resetn     = 1'b0;
      tick       = 1'b0;
      start      = 1'b0;
      user_input = 1'b1;
      next_input = 1'b1;
      done_input = 1'b1;
      #12;
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_recorded", 32'(recorded), 32'd0);
      check("rst_length",   32'(length),   32'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      step(2);

      // Basic commit: samples 1,0,1,0 -> 4'b1010.
      wq.delete();
      pulse_start();
      check("basic_busy", 32'(busy), 32'd1);
      sample_bit(1'b1);
      sample_bit(1'b0);
      sample_bit(1'b1);
      sample_bit(1'b0);
      check("basic_sym", 32'(cur_symbol), 32'hA);
      user_input = 1'b1;
      press_next();
      check("basic_nwr", 32'(wq.size()), 32'd1);
      check_write("basic_wr", 0, 5'd0, 4'hA);
      check("basic_len", 32'(length), 32'd1);
      check("basic_sym0", 32'(cur_symbol), 32'd0);
      check("basic_data_idle", 32'(ram_data), 32'd0);

      // Three symbols then done.
      wq.delete();
      pulse_start();
      check("three_len0", 32'(length), 32'd0);
      sample_bit(1'b1);
      press_next();
      sample_bit(1'b1);
      sample_bit(1'b1);
      press_next();
      for (int i = 0; i < 4; i++) sample_bit(1'b1);
      press_next();
      user_input = 1'b1;
      press_done();
      check("three_nwr", 32'(wq.size()), 32'd3);
      check_write("three_w0", 0, 5'd0, 4'h1);
      check_write("three_w1", 1, 5'd1, 4'h3);
      check_write("three_w2", 2, 5'd2, 4'hF);
      check("three_rec",  32'(recorded), 32'd1);
      check("three_len",  32'(length),   32'd3);
      check("three_busy", 32'(busy),     32'd0);

      // Done alone discards the partial symbol.
      wq.delete();
      pulse_start();
      sample_bit(1'b1);
      user_input = 1'b1;
      press_done();
      check("discard_nwr", 32'(wq.size()), 32'd0);
      check("discard_len", 32'(length), 32'd0);
      check("discard_rec", 32'(recorded), 32'd1);
      check("discard_sym", 32'(cur_symbol), 32'd0);

      // Simultaneous next + done with sym = 4'b0101.
      wq.delete();
      pulse_start();
      sample_bit(1'b0);
      sample_bit(1'b1);
      sample_bit(1'b0);
      sample_bit(1'b1);
      user_input = 1'b1;
      press_both();
      check("both_nwr", 32'(wq.size()), 32'd1);
      check_write("both_wr", 0, 5'd0, 4'h5);
      check("both_rec", 32'(recorded), 32'd1);
      check("both_len", 32'(length), 32'd1);

      // Tick lands in the same cycle as the next edge; key then held ~10 ticks.
      wq.delete();
      pulse_start();
      user_input = 1'b0;
      step(3);
      next_input = 1'b0;
      step(3);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(9);
         tick = 1'b1;
         step(1);
         tick = 1'b0;
      end
      next_input = 1'b1;
      user_input = 1'b1;
      step(8);
      check("coinc_nwr", 32'(wq.size()), 32'd1);
      check_write("coinc_wr", 0, 5'd0, 4'h1);
      check("coinc_len", 32'(length), 32'd1);
      check("coinc_busy", 32'(busy), 32'd1);

      // Full memory: 32 commits, then a 33rd press does nothing.
      wq.delete();
      pulse_start();
      for (int i = 0; i < 31; i++) press_next();
      check("full_rec31", 32'(recorded), 32'd0);
      press_next();
      check("full_nwr", 32'(wq.size()), 32'd32);
      for (int i = 0; i < 32; i++) check_write($sformatf("full_w%0d", i), i, 5'(i), 4'h0);
      check("full_rec", 32'(recorded), 32'd1);
      check("full_len", 32'(length), 32'd32);
      press_next();
      check("full_extra", 32'(wq.size()), 32'd32);
      check("full_len2", 32'(length), 32'd32);

      // Asynchronous reset in the middle of a recording.
      pulse_start();
      sample_bit(1'b1);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_sym", 32'(cur_symbol), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_rec",  32'(recorded), 32'd0);
      check("arst_len",  32'(length), 32'd0);
      check("arst_sym",  32'(cur_symbol), 32'd0);
      check("arst_wren", 32'(ram_wren), 32'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      user_input = 1'b1;
      step(3);
      check("arst_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
